// File: rtl/alu_issue_ctrl_pkg.sv
// Shared encodings for the ALU issue controller: opcodes, funct codes,
// ALU operation codes, operand-select and FSM state types.
package alu_issue_ctrl_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_MULI  = 6'h1D;

  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_MUL = 6'h2C;

  localparam logic [5:0] OPRN_NONE = 6'd0;
  localparam logic [5:0] OPRN_ADD  = 6'd1;
  localparam logic [5:0] OPRN_SUB  = 6'd2;
  localparam logic [5:0] OPRN_MUL  = 6'd3;
  localparam logic [5:0] OPRN_SRL  = 6'd4;
  localparam logic [5:0] OPRN_SLL  = 6'd5;
  localparam logic [5:0] OPRN_AND  = 6'd6;
  localparam logic [5:0] OPRN_OR   = 6'd7;
  localparam logic [5:0] OPRN_NOR  = 6'd8;
  localparam logic [5:0] OPRN_SLT  = 6'd9;

  // lui is executed as a left shift of the immediate by this amount
  localparam int LUI_SHIFT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  typedef enum logic {
    OP1_RS  = 1'b0,
    OP1_IMM = 1'b1
  } op1_sel_t;

  typedef enum logic [1:0] {
    OP2_RT  = 2'd0,
    OP2_IMM = 2'd1,
    OP2_C16 = 2'd2
  } op2_sel_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational instruction decoder: opcode/funct to ALU operation, operand
// selects, extended immediate, destination register and illegal flag.
module alu_issue_decode
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [31:0]           i_instr,
  output logic [5:0]            o_oprn,
  output op1_sel_t              o_op1_sel,
  output op2_sel_t              o_op2_sel,
  output logic [DATA_W-1:0]     o_imm,
  output logic [REG_ADDR_W-1:0] o_rs,
  output logic [REG_ADDR_W-1:0] o_rt,
  output logic [REG_ADDR_W-1:0] o_dest,
  output logic                  o_illegal
);

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_shamt;
  logic [15:0] w_imm16;
  logic [DATA_W-1:0] w_imm_sext;
  logic [DATA_W-1:0] w_imm_zext;
  logic [DATA_W-1:0] w_shamt_zext;

  assign w_opcode     = i_instr[31:26];
  assign w_funct      = i_instr[5:0];
  assign w_shamt      = i_instr[10:6];
  assign w_imm16      = i_instr[15:0];
  assign w_imm_sext   = {{(DATA_W-16){w_imm16[15]}}, w_imm16};
  assign w_imm_zext   = {{(DATA_W-16){1'b0}}, w_imm16};
  assign w_shamt_zext = {{(DATA_W-5){1'b0}}, w_shamt};

  assign o_rs = REG_ADDR_W'(i_instr[25:21]);
  assign o_rt = REG_ADDR_W'(i_instr[20:16]);

  always_comb begin
    o_oprn    = OPRN_NONE;
    o_op1_sel = OP1_RS;
    o_op2_sel = OP2_RT;
    o_imm     = w_imm_sext;
    o_dest    = REG_ADDR_W'(i_instr[20:16]);
    o_illegal = 1'b0;
    unique case (w_opcode)
      OPC_RTYPE: begin
        o_dest = REG_ADDR_W'(i_instr[15:11]);
        o_imm  = w_shamt_zext;
        unique case (w_funct)
          FN_ADD:  o_oprn = OPRN_ADD;
          FN_SUB:  o_oprn = OPRN_SUB;
          FN_MUL:  o_oprn = OPRN_MUL;
          FN_AND:  o_oprn = OPRN_AND;
          FN_OR:   o_oprn = OPRN_OR;
          FN_NOR:  o_oprn = OPRN_NOR;
          FN_SLT:  o_oprn = OPRN_SLT;
          FN_SRL: begin
            o_oprn    = OPRN_SRL;
            o_op2_sel = OP2_IMM;
          end
          FN_SLL: begin
            o_oprn    = OPRN_SLL;
            o_op2_sel = OP2_IMM;
          end
          default: o_illegal = 1'b1;
        endcase
      end
      OPC_ADDI: begin
        o_oprn    = OPRN_ADD;
        o_op2_sel = OP2_IMM;
      end
      OPC_MULI: begin
        o_oprn    = OPRN_MUL;
        o_op2_sel = OP2_IMM;
      end
      OPC_SLTI: begin
        o_oprn    = OPRN_SLT;
        o_op2_sel = OP2_IMM;
      end
      OPC_ANDI: begin
        o_oprn    = OPRN_AND;
        o_op2_sel = OP2_IMM;
        o_imm     = w_imm_zext;
      end
      OPC_ORI: begin
        o_oprn    = OPRN_OR;
        o_op2_sel = OP2_IMM;
        o_imm     = w_imm_zext;
      end
      OPC_LUI: begin
        o_oprn    = OPRN_SLL;
        o_op1_sel = OP1_IMM;
        o_op2_sel = OP2_C16;
        o_imm     = w_imm_zext;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer feeding a combinational 32-bit ALU and the register
// file write port. Optional operand forwarding: define ALU_ISSUE_BYPASS_EN.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  INSTR_VALID,
  output logic                  INSTR_READY,
  input  logic [31:0]           INSTR,
  input  logic [DATA_W-1:0]     RS_DATA,
  input  logic [DATA_W-1:0]     RT_DATA,
  output logic [DATA_W-1:0]     ALU_OP1,
  output logic [DATA_W-1:0]     ALU_OP2,
  output logic [5:0]            ALU_OPRN,
  input  logic [DATA_W-1:0]     ALU_RESULT,
  input  logic [31:0]           ALU_ZERO,
  output logic                  WB_VALID,
  input  logic                  WB_READY,
  output logic [REG_ADDR_W-1:0] WB_ADDR,
  output logic [DATA_W-1:0]     WB_DATA,
  output logic                  WB_ZERO,
  output logic                  ILLEGAL
);

  localparam logic [DATA_W-1:0] C_LUI_SHIFT = DATA_W'(LUI_SHIFT);

  state_t                  r_state;
  logic                    r_instr_ready;
  logic [DATA_W-1:0]       r_op1;
  logic [DATA_W-1:0]       r_op2;
  logic [5:0]              r_oprn;
  logic [REG_ADDR_W-1:0]   r_dest;
  logic                    r_wb_valid;
  logic [REG_ADDR_W-1:0]   r_wb_addr;
  logic [DATA_W-1:0]       r_wb_data;
  logic                    r_wb_zero;
  logic                    r_illegal;

  logic [5:0]              w_oprn;
  op1_sel_t                w_op1_sel;
  op2_sel_t                w_op2_sel;
  logic [DATA_W-1:0]       w_imm;
  logic [REG_ADDR_W-1:0]   w_rs;
  logic [REG_ADDR_W-1:0]   w_rt;
  logic [REG_ADDR_W-1:0]   w_dest;
  logic                    w_illegal;
  logic [DATA_W-1:0]       w_rs_val;
  logic [DATA_W-1:0]       w_rt_val;
  logic [DATA_W-1:0]       w_op1;
  logic [DATA_W-1:0]       w_op2;
  logic                    w_accept;
  logic                    w_wb_fire;
  logic                    w_unused;

  alu_issue_decode #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_decode (
    .i_instr   (INSTR),
    .o_oprn    (w_oprn),
    .o_op1_sel (w_op1_sel),
    .o_op2_sel (w_op2_sel),
    .o_imm     (w_imm),
    .o_rs      (w_rs),
    .o_rt      (w_rt),
    .o_dest    (w_dest),
    .o_illegal (w_illegal)
  );

  assign w_accept  = INSTR_VALID && r_instr_ready;
  assign w_wb_fire = r_wb_valid && WB_READY;

`ifdef ALU_ISSUE_BYPASS_EN
  logic                  r_fwd_valid;
  logic [REG_ADDR_W-1:0] r_fwd_addr;
  logic [DATA_W-1:0]     r_fwd_data;
  logic                  w_fwd_rs;
  logic                  w_fwd_rt;

  // Remembers the most recent result handed to the register file
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fwd_valid <= 1'b0;
      r_fwd_addr  <= '0;
      r_fwd_data  <= '0;
    end else if (w_wb_fire) begin
      r_fwd_valid <= 1'b1;
      r_fwd_addr  <= r_wb_addr;
      r_fwd_data  <= r_wb_data;
    end
  end

  assign w_fwd_rs = r_fwd_valid && (r_fwd_addr != '0) && (r_fwd_addr == w_rs);
  assign w_fwd_rt = r_fwd_valid && (r_fwd_addr != '0) && (r_fwd_addr == w_rt);
  assign w_rs_val = w_fwd_rs ? r_fwd_data : RS_DATA;
  assign w_rt_val = w_fwd_rt ? r_fwd_data : RT_DATA;
  assign w_unused = ^ALU_ZERO[31:1];
`else
  assign w_rs_val = RS_DATA;
  assign w_rt_val = RT_DATA;
  assign w_unused = ^{ALU_ZERO[31:1], w_rs, w_rt};
`endif

  always_comb begin
    w_op1 = (w_op1_sel == OP1_IMM) ? w_imm : w_rs_val;
    unique case (w_op2_sel)
      OP2_IMM: w_op2 = w_imm;
      OP2_C16: w_op2 = C_LUI_SHIFT;
      default: w_op2 = w_rt_val;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= ST_IDLE;
      r_instr_ready <= 1'b1;
      r_op1         <= '0;
      r_op2         <= '0;
      r_oprn        <= OPRN_NONE;
      r_dest        <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_addr     <= '0;
      r_wb_data     <= '0;
      r_wb_zero     <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_illegal) begin
              r_illegal <= 1'b1;
            end else begin
              r_op1         <= w_op1;
              r_op2         <= w_op2;
              r_oprn        <= w_oprn;
              r_dest        <= w_dest;
              r_instr_ready <= 1'b0;
              r_state       <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          r_wb_data <= ALU_RESULT;
          r_wb_zero <= ALU_ZERO[0];
          // Writes to register 0 are dropped, so no handshake is offered
          if (r_dest != '0) begin
            r_wb_addr  <= r_dest;
            r_wb_valid <= 1'b1;
            r_state    <= ST_WB;
          end else begin
            r_instr_ready <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        ST_WB: begin
          if (w_wb_fire) begin
            r_wb_valid    <= 1'b0;
            r_instr_ready <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        default: begin
          r_wb_valid    <= 1'b0;
          r_instr_ready <= 1'b1;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign INSTR_READY = r_instr_ready;
  assign ALU_OP1     = r_op1;
  assign ALU_OP2     = r_op2;
  assign ALU_OPRN    = r_oprn;
  assign WB_VALID    = r_wb_valid;
  assign WB_ADDR     = r_wb_addr;
  assign WB_DATA     = r_wb_data;
  assign WB_ZERO     = r_wb_zero;
  assign ILLEGAL     = r_illegal;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Execute-stage sequencer directly upstream of the 32-bit ALU.
- Accepts one decoded R/I-type instruction plus register-file read data over a valid/ready handshake.
- Drives registered OP1/OP2/OPRN into the ALU and captures its result and zero flag one cycle later.
- Presents the result to the register-file write port over a second valid/ready handshake.

Parameters:
DATA_W, 32, operand/result width
REG_ADDR_W, 5, register address width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
INSTR_VALID  in  1  instruction offered
INSTR_READY  out  1  block can accept an instruction
INSTR  in  32  instruction: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct, [15:0] imm
RS_DATA  in  32  rs read data, valid with INSTR_VALID
RT_DATA  in  32  rt read data, valid with INSTR_VALID
ALU_OP1  out  32  ALU operand 1
ALU_OP2  out  32  ALU operand 2
ALU_OPRN  out  6  ALU operation code
ALU_RESULT  in  32  ALU combinational result
ALU_ZERO  in  32  ALU zero flag; only bit 0 used
WB_VALID  out  1  writeback offered
WB_READY  in  1  register file accepts writeback
WB_ADDR  out  5  destination register
WB_DATA  out  32  result to write
WB_ZERO  out  1  captured zero flag
ILLEGAL  out  1  one-cycle pulse on an undecodable instruction

Behaviour:
- Reset (async, RST=1): state IDLE.
  - INSTR_READY=1; WB_VALID=0; ILLEGAL=0.
  - ALU_OP1=0, ALU_OP2=0, ALU_OPRN=0; WB_ADDR=0, WB_DATA=0, WB_ZERO=0.
  - RST mid-operation aborts the instruction; no writeback is issued.
- FSM states: IDLE, EXEC, WB.
  - IDLE: INSTR_READY=1. On INSTR_VALID&INSTR_READY at edge N:
    - Legal instruction: register operands/OPRN/dest; go to EXEC.
    - Illegal instruction: ILLEGAL=1 for the cycle after edge N; stay in IDLE.
  - EXEC: INSTR_READY=0. The ALU settles combinationally. At edge N+1, capture WB_DATA=ALU_RESULT and WB_ZERO=ALU_ZERO[0].
    - dest!=0: go to WB.
    - dest==0: writeback suppressed, go to IDLE.
  - WB: WB_VALID=1; WB_ADDR/DATA/ZERO held stable until WB_READY.
    - On WB_VALID&WB_READY: go to IDLE.
    - WB_READY already high on WB entry: exactly one WB cycle.
- Latency: accept edge N -> WB_VALID high after edge N+1. Minimum 3 cycles per instruction.
- ALU_OP1/OP2/OPRN hold their last values outside EXEC.
- R-type decode (opcode 0x00), funct -> OPRN, OP1/OP2:
  - 0x20 add -> 1: RS, RT
  - 0x22 sub -> 2: RS, RT
  - 0x2C mul -> 3: RS, RT
  - 0x02 srl -> 4: RS, zero-extended shamt
  - 0x01 sll -> 5: RS, zero-extended shamt
  - 0x24 and -> 6: RS, RT
  - 0x25 or -> 7: RS, RT
  - 0x27 nor -> 8: RS, RT
  - 0x2A slt -> 9: RS, RT
  - R-type destination = rd.
- I-type decode, destination = rt:
  - 0x08 addi -> 1, sign-extended imm
  - 0x1D muli -> 3, sign-extended imm
  - 0x0A slti -> 9, sign-extended imm
  - 0x0C andi -> 6, zero-extended imm
  - 0x0D ori -> 7, zero-extended imm
  - 0x0F lui -> 5, OP1=zero-extended imm, OP2=16
- Any other opcode/funct is illegal.
- INSTR_VALID while not ready is ignored; the upstream source holds it.

Optional Feature:
ALU_ISSUE_BYPASS_EN
- Defined: a 1-entry forwarding register holds the last accepted writeback (addr, data, valid).
  - At accept, rs/rt matching a nonzero forwarded addr take the forwarded data instead of RS_DATA/RT_DATA.
  - The forwarding entry is cleared by RST.
- Undefined: RS_DATA/RT_DATA are always used directly; no forwarding storage is built.

Decomposition:
- prj_definition.v holds:
  - opcode/funct constants
  - ALU OPRN codes 1..9
  - FSM state encodings
- One natural sub-module: alu_issue_decode.
  - Combinational; maps INSTR to OPRN, operand-select, immediate-extend, dest and illegal.
  - Instantiated once.

Test Plan:
- add $3,$1,$2, RS=5, RT=7, WB_READY=1 -> OPRN=1, OP1=5, OP2=7; WB_VALID after edge N+1; WB_ADDR=3, WB_DATA=12, WB_ZERO=0.
- sub $4,$1,$2, RS=RT=0x0000_0009 -> WB_DATA=0, WB_ZERO=1. slti rt=5, RS=0xFFFF_FFFE, imm=0xFFFF -> OP2=0xFFFF_FFFF, OPRN=9.
- lui $6,0x1234 -> OP1=0x1234, OP2=16, OPRN=5. WB_READY held low 4 cycles -> WB_VALID and WB_DATA stable all 4 cycles, INSTR_READY=0, then IDLE.
- opcode 0x3F -> ILLEGAL one-cycle pulse, no WB_VALID, INSTR_READY stays 1. add $0,$1,$2 -> no WB_VALID, back to IDLE after EXEC.
- RST asserted during EXEC (async, mid-cycle) -> outputs at reset values immediately, no WB issued, next instruction accepted normally.
- With ALU_ISSUE_BYPASS_EN: add $3 -> 12, then add $5,$3,$3 with RS_DATA=RT_DATA=0 -> WB_DATA=24. Without the macro -> WB_DATA=0.
